// File: rtl/exp_coherent_acc.sv
// exp_coherent_acc: accumulates acc_num rounds of BIN_NUM exp10 complex
// samples bin-by-bin, then streams the accumulated bins downstream.
// Optional build macro EXP_SAT_EN: saturate instead of wrapping when an
// overflow occurs at exponent 15, and report it on a sticky exp_sat flag.
//
// state | meaning
// IDLE  | waiting for start
// ACC   | accepting samples, one bin per handshake, round after round
// DUMP  | presenting accumulated bins 0..BIN_NUM-1 on the output
module exp_coherent_acc #(
  parameter int BIN_NUM = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [5:0] acc_num,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_i,
  input  logic [9:0] in_q,
  input  logic [3:0] in_exp,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_i,
  output logic [9:0] out_q,
  output logic [3:0] out_exp,
  output logic       busy,
  output logic       done,
  output logic       exp_sat
);

  localparam int BW = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     bin_cnt;
  logic [5:0]        round_cnt;
  logic [5:0]        last_round_idx;
  logic [23:0]       acc_buf [BIN_NUM];

  logic              in_hs, out_hs, last_bin, last_round;
  logic [9:0]        a_i, a_q;
  logic [3:0]        a_e;
  logic signed [4:0] d, nd;
  logic [3:0]        sh, e_max;
  logic signed [9:0] m_i1, m_q1, m_i2, m_q2;
  logic [10:0]       sum_i, sum_q;
  logic              ovf_i, ovf_q;
  logic [9:0]        r_i, r_q;
  logic [3:0]        r_e;
  logic              sat_hit;
  logic [23:0]       wr_data;

  assign in_ready   = (state == ACC);
  assign busy       = (state != IDLE);
  assign in_hs      = in_valid && (state == ACC);
  assign out_hs     = out_valid && out_ready && (state == DUMP);
  assign last_bin   = (bin_cnt == BW'(BIN_NUM - 1));
  assign last_round = (round_cnt == last_round_idx);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (in_hs && last_bin && last_round) state_nxt = DUMP;
      DUMP:    if (out_hs && last_bin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Exp-add of the stored bin with the incoming sample
  always_comb begin
    a_i     = acc_buf[bin_cnt][23:14];
    a_q     = acc_buf[bin_cnt][13:4];
    a_e     = acc_buf[bin_cnt][3:0];
    d       = $signed({1'b0, a_e}) - $signed({1'b0, in_exp});
    nd      = -d;
    sh      = 4'd0;
    e_max   = a_e;
    m_i1    = $signed(a_i);
    m_q1    = $signed(a_q);
    m_i2    = $signed(in_i);
    m_q2    = $signed(in_q);
    sat_hit = 1'b0;
    if (!d[4]) begin
      sh    = d[3:0];
      e_max = a_e;
      m_i2  = $signed(in_i) >>> sh;
      m_q2  = $signed(in_q) >>> sh;
    end else begin
      sh    = nd[3:0];
      e_max = in_exp;
      m_i1  = $signed(a_i) >>> sh;
      m_q1  = $signed(a_q) >>> sh;
    end
    sum_i = {m_i1[9], m_i1} + {m_i2[9], m_i2};
    sum_q = {m_q1[9], m_q1} + {m_q2[9], m_q2};
    ovf_i = sum_i[10] ^ sum_i[9];
    ovf_q = sum_q[10] ^ sum_q[9];
    r_i   = sum_i[9:0];
    r_q   = sum_q[9:0];
    r_e   = e_max;
    if (ovf_i || ovf_q) begin
      r_i = sum_i[10:1];
      r_q = sum_q[10:1];
      r_e = e_max + 4'd1;
`ifdef EXP_SAT_EN
      if (e_max == 4'd15) begin
        sat_hit = 1'b1;
        r_e     = 4'd15;
        r_i     = ovf_i ? (sum_i[10] ? 10'h200 : 10'h1ff) : sum_i[9:0];
        r_q     = ovf_q ? (sum_q[10] ? 10'h200 : 10'h1ff) : sum_q[9:0];
      end
`endif
    end
    wr_data = (round_cnt == 6'd0) ? {in_i, in_q, in_exp} : {r_i, r_q, r_e};
  end

  // Bin buffer; round 0 overwrites every entry so no reset is needed
  always_ff @(posedge clk) begin
    if (in_hs) acc_buf[bin_cnt] <= wr_data;
  end

  // Counters, registered output stage and done pulse
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      bin_cnt        <= '0;
      round_cnt      <= '0;
      last_round_idx <= '0;
      out_valid      <= 1'b0;
      out_i          <= '0;
      out_q          <= '0;
      out_exp        <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bin_cnt        <= '0;
          round_cnt      <= '0;
          last_round_idx <= (acc_num == 6'd0) ? 6'd0 : acc_num - 6'd1;
        end
        ACC: if (in_hs) begin
          bin_cnt <= bin_cnt + BW'(1);
          if (last_bin) round_cnt <= round_cnt + 6'd1;
          if (last_bin && last_round) begin
            out_valid <= 1'b1;
            {out_i, out_q, out_exp} <= acc_buf[0];
          end
        end
        DUMP: if (out_hs) begin
          bin_cnt <= bin_cnt + BW'(1);
          if (last_bin) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            {out_i, out_q, out_exp} <= acc_buf[bin_cnt + BW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EXP_SAT_EN
  logic exp_sat_r;

  // Sticky saturation flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_b)                        exp_sat_r <= 1'b0;
    else if (state == IDLE && start)   exp_sat_r <= 1'b0;
    else if (in_hs && round_cnt != 6'd0 && sat_hit) exp_sat_r <= 1'b1;
  end

  assign exp_sat = exp_sat_r;
`else
  assign exp_sat = 1'b0;
`endif

endmodule

// File: tb/tb_exp_coherent_acc.sv
// Scoreboard bench for exp_coherent_acc: stimulus pushes expected bins,
// a negedge monitor pops and compares on every output handshake.
module tb_exp_coherent_acc;
  localparam int BN = 16;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [5:0] acc_num = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_i = '0, in_q = '0;
  logic [3:0] in_exp = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_i, out_q;
  logic [3:0] out_exp;
  logic       busy, done, exp_sat;

  always #5 clk = ~clk;

  exp_coherent_acc #(.BIN_NUM(BN)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .acc_num(acc_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_i(out_i), .out_q(out_q), .out_exp(out_exp), .busy(busy),
    .done(done), .exp_sat(exp_sat)
  );

  typedef struct {
    logic [9:0] i;
    logic [9:0] q;
    logic [3:0] e;
    bit         last;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   n_chk = 0, n_pass = 0;
  bit   bp_mode = 0;
  int   stall_left = 0;
  int   dump_idx = 0;
  bit   exp_done = 0;

  logic [9:0] vi [2][BN];
  logic [9:0] vq [2][BN];
  logic [3:0] ve [2][BN];
  logic [9:0] xi [BN];
  logic [9:0] xq [BN];
  logic [3:0] xe [BN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: drives out_ready, checks held data under stall and each handshake
  always @(negedge clk) begin
    if (!rst_b) begin
      dump_idx  = 0;
      exp_done  = 0;
      out_ready = 1'b1;
    end else begin
      if (exp_done || done) begin
        chk("done_pulse", done, exp_done);
        if (exp_done) chk("busy_at_done", busy, 0);
      end
      exp_done  = 0;
      out_ready = 1'b1;
      if (out_valid && bp_mode && dump_idx == 5 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (sb.size() > 0) begin
          chk("hold_i", out_i, sb[0].i);
          chk("hold_q", out_q, sb[0].q);
          chk("hold_e", out_exp, sb[0].e);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got %0h/%0h/%0h required none", out_i, out_q, out_exp);
        end else begin
          popped = sb.pop_front();
          chk($sformatf("out_i bin%0d", dump_idx), out_i, popped.i);
          chk($sformatf("out_q bin%0d", dump_idx), out_q, popped.q);
          chk($sformatf("out_e bin%0d", dump_idx), out_exp, popped.e);
          dump_idx++;
          if (popped.last) begin
            exp_done = 1;
            dump_idx = 0;
          end
        end
      end
    end
  end

  task automatic feed(input logic [9:0] i, input logic [9:0] q, input logic [3:0] e);
    int t = 0;
    in_i = i; in_q = q; in_exp = e; in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_chk++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_job(input logic [5:0] an);
    acc_num = an;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("in_ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_job(input logic [5:0] an, input int nr);
    int t = 0;
    exp_t x;
    for (int k = 0; k < BN; k++) begin
      x.i = xi[k]; x.q = xq[k]; x.e = xe[k]; x.last = (k == BN - 1);
      sb.push_back(x);
    end
    start_job(an);
    for (int r = 0; r < nr; r++)
      for (int k = 0; k < BN; k++)
        feed(vi[r][k], vq[r][k], ve[r][k]);
    chk("in_ready_in_dump", in_ready, 0);
    while ((sb.size() > 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      $display("FAIL job_timeout: got %0d pending required 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic fill(input int r, input int i, input int q, input int e);
    for (int k = 0; k < BN; k++) begin
      vi[r][k] = 10'(i); vq[r][k] = 10'(q); ve[r][k] = 4'(e);
    end
  endtask

  task automatic want(input int i, input int q, input int e);
    for (int k = 0; k < BN; k++) begin
      xi[k] = 10'(i); xq[k] = 10'(q); xe[k] = 4'(e);
    end
  endtask

  task automatic setup_ramp();
    for (int k = 0; k < BN; k++) begin
      vi[0][k] = 10'(k); vq[0][k] = 10'(-k); ve[0][k] = 4'd2;
      vi[1][k] = 10'(k); vq[1][k] = 10'(-k); ve[1][k] = 4'd2;
      xi[k] = 10'(k); xq[k] = 10'(-k); xe[k] = 4'd2;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_i"}, out_i, 0);
    chk({tag, "_out_q"}, out_q, 0);
    chk({tag, "_out_exp"}, out_exp, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_exp_sat"}, exp_sat, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_b = 1'b1;
    @(negedge clk);

    // ramp, single round
    setup_ramp();
    run_job(6'd1, 1);
    chk("exp_sat_ramp", exp_sat, 0);

    // acc_num=0 behaves as one round
    run_job(6'd0, 1);

    // back-pressure at bin 5
    bp_mode = 1; stall_left = 3;
    run_job(6'd1, 1);
    bp_mode = 0;
    chk("stall_consumed", stall_left, 0);

    // overflow renormalisation: 300+300
    fill(0, 300, 0, 0); fill(1, 300, 0, 0); want(300, 0, 1);
    run_job(6'd2, 2);

    // exponent alignment, even bins buffer larger, odd bins input larger
    for (int k = 0; k < BN; k++) begin
      if (k % 2 == 0) begin
        vi[0][k] = 10'd256; vq[0][k] = 10'(-256); ve[0][k] = 4'd5;
        vi[1][k] = 10'd64;  vq[1][k] = 10'd64;    ve[1][k] = 4'd3;
      end else begin
        vi[0][k] = 10'd64;  vq[0][k] = 10'd64;    ve[0][k] = 4'd3;
        vi[1][k] = 10'd256; vq[1][k] = 10'(-256); ve[1][k] = 4'd5;
      end
    end
    want(272, -240, 5);
    run_job(6'd2, 2);

    // large exponent gap: shifted to sign bits
    fill(0, 100, 0, 12); fill(1, -7, 5, 0); want(99, 0, 12);
    run_job(6'd2, 2);

    // overflow at exponent 15
    fill(0, 511, -512, 15); fill(1, 511, -512, 15);
`ifdef EXP_SAT_EN
    want(511, -512, 15);
    run_job(6'd2, 2);
    chk("exp_sat_set", exp_sat, 1);
`else
    want(511, -512, 0);
    run_job(6'd2, 2);
    chk("exp_sat_tied", exp_sat, 0);
`endif

    // reset mid-ACC at round 1, bin 7
    setup_ramp();
    start_job(6'd2);
    for (int k = 0; k < BN + 7; k++) feed(vi[k / BN][k % BN], vq[k / BN][k % BN], ve[k / BN][k % BN]);
    chk("busy_mid_acc", busy, 1);
    rst_b = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    rst_b = 1'b1;
    @(negedge clk);
    run_job(6'd1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule

// File: doc/exp_coherent_acc.md
# exp_coherent_acc

Coherent accumulator for the acquisition engine that sits directly downstream of the exp10 complex adder datapath. It takes a stream of exp10-format complex correlation results (10-bit signed I/Q mantissas sharing one 4-bit exponent) covering BIN_NUM search bins per round. It accumulates `acc_num` rounds bin-by-bin into an internal buffer, then streams the BIN_NUM accumulated results to the non-coherent stage.

## Interface
- BIN_NUM, 16, bins per round; power of two, 2..64
- clk  input  1  system clock
- rst_b  input  1  reset, synchronous, active-low
- start  input  1  pulse; begins a new accumulation, honoured only in IDLE
- acc_num  input  6  rounds to accumulate, sampled on accepted start; 0 treated as 1
- in_valid  input  1  input sample valid
- in_ready  output  1  input accepted when in_valid & in_ready
- in_i, in_q  input  10 each  signed mantissas
- in_exp  input  4  unsigned exponent
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_i, out_q  output  10 each  accumulated mantissas
- out_exp  output  4  accumulated exponent
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after last result accepted
- exp_sat  output  1  sticky saturation flag (only with EXP_SAT_EN, else tied 0)

## Operation
- States:
  - IDLE: on start → ACC. Clears bin_cnt and round_cnt, latches acc_num, clears exp_sat.
  - ACC: each handshake processes bin bin_cnt. bin_cnt wraps BIN_NUM-1→0 and increments round_cnt. The handshake on the last bin of the last round → DUMP.
  - DUMP: presents buf[bin_cnt] starting at bin 0. Each out handshake increments bin_cnt. The handshake on bin BIN_NUM-1 → IDLE and asserts done for one cycle.
- Round 0 writes the input straight into buf[bin_cnt]. Later rounds write exp-add(buf[bin_cnt], input).
- Exp-add:
  - d = e1 − e2 (5-bit signed). Keep max exponent.
  - Arithmetic right-shift the smaller-exponent mantissas by |d|. For |d| ≥ 9 the result is all sign bits.
  - Sign-extend to 11 bits and add.
  - Overflow if bit10≠bit9 in either I or Q sum. On overflow, take sum[10:1] for both components and exp+1; otherwise take sum[9:0].
- Buffer is BIN_NUM × 24-bit registers. Not reset; round 0 overwrites every entry.
- start while busy: ignored. in_valid outside ACC: ignored. in_ready = (state==ACC).

## Timing
- Reset values: in_ready 0, out_valid 0, out_i/out_q/out_exp 0, busy 0, done 0, exp_sat 0, state IDLE, counters 0.
- rst_b low in any state aborts on the next edge; partial results are discarded.
- start accepted at edge N; busy=1 and in_ready=1 from N+1.
- Input handshake at edge K: the buffer entry is updated at K, and in_ready stays high, so one sample per cycle at full throughput.
- ACC→DUMP at the last input edge. out_valid=1 the next cycle with bin 0, driven from the registered output.
- Outputs hold stable while out_valid & !out_ready. Full throughput is one result per cycle.
- done is high for exactly the cycle after the final out handshake, with busy=0 in that same cycle. A start in that cycle is accepted.
- Total for acc_num=R with no stalls: R·BIN_NUM input cycles + BIN_NUM output cycles.

## Configuration
- EXP_SAT_EN defined:
  - When overflow occurs with max exponent 15, out_exp stays 15.
  - Each mantissa saturates to +511 or −512 according to the sign of its 11-bit sum; a non-overflowing component takes sum[9:0].
  - exp_sat sets and holds until the next accepted start.
- EXP_SAT_EN undefined: the exponent wraps modulo 16 (15+1 → 0), mantissas take sum[10:1], and exp_sat is tied 0.

## Test plan
- BIN_NUM=16, acc_num=1, inputs bin k = (k, −k, exp 2) → outputs bin k = (k, −k, 2); done one cycle after 16th out handshake.
- acc_num=2, both rounds (300, 0, exp 0) → (300, 0, 0) overflows 600 → outputs (300, 0, exp 1).
- acc_num=2, round0 (256, −256, exp 5), round1 (64, 64, exp 3) → shift 2 gives (16, 16) → out (272, −240, exp 5); swapped order gives same result.
- acc_num=2, round0 (100, 0, exp 12), round1 (−7, 5, exp 0), |d|=12 → shifted (−1, 0) → out (99, 0, exp 12).
- EXP_SAT_EN, acc_num=2, both (511, −512, exp 15) → out (511, −512, exp 15), exp_sat=1; without macro → (511, −512, exp 0).
- Back-pressure: out_ready low 3 cycles at bin 5 → bin 5 held stable, no loss. rst_b low mid-ACC (round 1, bin 7) → IDLE next edge, all outputs 0, new start runs cleanly. acc_num=0 behaves as 1.
